// File: rtl/base2_exp_arbiter.sv
// base2_exp_arbiter: round-robin share of one fixed-latency base-2 exp unit
// between N_REQ requesters, with a tag FIFO routing results back to their
// owners in issue order.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req_valid/req_a   per-requester operand valid and 32-bit operands
//   req_ready         one-hot grant (transfer = req_valid & req_ready)
//   exp_in_valid/a    issue strobe and operand to the exp unit
//   exp_out_valid/c   result strobe and data from the exp unit
//   resp_valid/c      one-hot result strobe and shared result data
//   busy              outstanding work or post-reset drain in progress
//   err               sticky: result strobe arrived with no tag outstanding
module base2_exp_arbiter #(
    parameter int    N_REQ     = 4,
    parameter int    LATENCY   = 8,
    parameter string PRECISION = "HALF"
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*32-1:0] req_a,
    output logic [N_REQ-1:0]    req_ready,
    output logic                exp_in_valid,
    output logic [31:0]         exp_a,
    input  logic                exp_out_valid,
    input  logic [31:0]         exp_c,
    output logic [N_REQ-1:0]    resp_valid,
    output logic [31:0]         resp_c,
    output logic                busy,
    output logic                err
);

    localparam int TW    = $clog2(N_REQ);
    localparam int DEPTH = LATENCY + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int OW    = $clog2(DEPTH + 1);
    localparam int CW    = $clog2(LATENCY + 1);

    generate
        if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
            $error("base2_exp_arbiter: N_REQ must be 2..8");
        end
        if (LATENCY < 1) begin : g_bad_lat
            $error("base2_exp_arbiter: LATENCY must be at least 1");
        end
        if (PRECISION != "HALF" && PRECISION != "SINGLE") begin : g_bad_prec
            $error("base2_exp_arbiter: PRECISION must be HALF or SINGLE");
        end
    endgenerate

    typedef enum logic {
        ST_DRAIN,
        ST_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     last_grant_q, last_grant_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]     count_q, count_d;
    logic [TW-1:0]     fifo_q [DEPTH];
    logic [TW-1:0]     fifo_d [DEPTH];
    logic              exp_in_valid_q, exp_in_valid_d;
    logic [31:0]       exp_a_q, exp_a_d;
    logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic [31:0]       resp_c_q, resp_c_d;
    logic              err_q, err_d;

    logic              run;
    logic              full;
    logic              empty;
    logic              grant_found;
    logic [TW-1:0]     grant_idx;
    logic [TW:0]       cand;
    logic              xfer;
    logic              pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_DRAIN;
            cnt_q   <= CW'(LATENCY);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---- FSM: next state ----
    // DRAIN lasts LATENCY+1 cycles so any result issued before a reset
    // lands inside the window and is discarded.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ---- round-robin search, starting after the last grant ----
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_grant_q} + (TW + 1)'(k);
            if (cand >= (TW + 1)'(N_REQ)) begin
                cand = cand - (TW + 1)'(N_REQ);
            end
            if (!grant_found && req_valid[cand[TW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[TW-1:0];
            end
        end
    end

    // ---- FSM: outputs ----
    always_comb begin
        run   = (state_q == ST_RUN);
        full  = (count_q == OW'(DEPTH));
        empty = (count_q == '0);
        req_ready = '0;
        if (run && !full && grant_found) begin
            req_ready = N_REQ'(1) << grant_idx;
        end
        busy = !run || !empty || (|resp_valid_q);
    end

    // ---- issue, tag FIFO and response datapath ----
    always_comb begin
        xfer = |(req_valid & req_ready);
        pop  = run && exp_out_valid && !empty;

        last_grant_d   = xfer ? grant_idx : last_grant_q;
        exp_in_valid_d = xfer;
        exp_a_d        = xfer ? req_a[32*grant_idx +: 32] : exp_a_q;

        fifo_d = fifo_q;
        if (xfer) begin
            fifo_d[wr_ptr_q] = grant_idx;
        end
        wr_ptr_d = xfer ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        unique case ({xfer, pop})
            2'b10:   count_d = count_q + OW'(1);
            2'b01:   count_d = count_q - OW'(1);
            default: count_d = count_q;
        endcase

        resp_valid_d = '0;
        if (pop) begin
            resp_valid_d = N_REQ'(1) << fifo_q[rd_ptr_q];
        end
        resp_c_d = pop ? exp_c : resp_c_q;

        // A strobe with nothing outstanding means LATENCY is wrong or the
        // unit misbehaved; the result is dropped.
        err_d = err_q | (run && exp_out_valid && empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q   <= TW'(N_REQ - 1);
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            exp_in_valid_q <= 1'b0;
            exp_a_q        <= '0;
            resp_valid_q   <= '0;
            resp_c_q       <= '0;
            err_q          <= 1'b0;
        end else begin
            last_grant_q   <= last_grant_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            exp_in_valid_q <= exp_in_valid_d;
            exp_a_q        <= exp_a_d;
            resp_valid_q   <= resp_valid_d;
            resp_c_q       <= resp_c_d;
            err_q          <= err_d;
        end
    end

    // Tag storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign exp_in_valid = exp_in_valid_q;
    assign exp_a        = exp_a_q;
    assign resp_valid   = resp_valid_q;
    assign resp_c       = resp_c_q;
    assign err          = err_q;

endmodule

// File: tb/tb_base2_exp_arbiter.sv
// tb_base2_exp_arbiter: scoreboard bench for base2_exp_arbiter with a
// behavioural fixed-latency exp unit (result = operand + 0x400).
module tb_base2_exp_arbiter;

    localparam int N = 4;
    localparam int L = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*32-1:0] req_a = '0;
    logic [N-1:0]   req_ready;
    logic           exp_in_valid;
    logic [31:0]    exp_a;
    logic           exp_out_valid;
    logic [31:0]    exp_c;
    logic [N-1:0]   resp_valid;
    logic [31:0]    resp_c;
    logic           busy;
    logic           err;

    base2_exp_arbiter #(
        .N_REQ(N),
        .LATENCY(L),
        .PRECISION("HALF")
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_a(req_a),
        .req_ready(req_ready),
        .exp_in_valid(exp_in_valid),
        .exp_a(exp_a),
        .exp_out_valid(exp_out_valid),
        .exp_c(exp_c),
        .resp_valid(resp_valid),
        .resp_c(resp_c),
        .busy(busy),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          tag;
        logic [31:0] c;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // exp unit model: L-stage pipeline, not reset (stale results survive)
    logic           spur = 1'b0;
    logic [L-1:0]   pv = '0;
    logic [31:0]    pa [L];

    always @(posedge clk) begin
        pv    <= {pv[L-2:0], exp_in_valid};
        pa[0] <= exp_a;
        for (int k = 1; k < L; k++) pa[k] <= pa[k-1];
        cyc   <= cyc + 1;
    end

    assign exp_out_valid = pv[L-1] | spur;
    assign exp_c         = pa[L-1] + 32'h400;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // response monitor: every resp_valid must match the queue head
    always @(negedge clk) begin
        if (resp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_tag", 64'(resp_valid), 64'(4'(1) << mon_e.tag));
                chk("resp_c", 64'(resp_c), 64'(mon_e.c));
                chk("resp_latency", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    function automatic logic [N*32-1:0] vec(input int s);
        logic [N*32-1:0] v;
        for (int i = 0; i < N; i++) v[32*i +: 32] = 32'h1000 + 32'(s * 16 + i);
        return v;
    endfunction

    task automatic step(input logic [N-1:0] vld, input logic [N*32-1:0] a,
                        input logic [N-1:0] rdy, input string tag);
        @(negedge clk);
        #1;
        req_valid = vld;
        req_a     = a;
        #1;
        chk(tag, 64'(req_ready), 64'(rdy));
        for (int i = 0; i < N; i++) begin
            if (vld[i] && req_ready[i])
                sb.push_back('{i, a[32*i +: 32] + 32'h400, cyc + L + 2});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        req_valid = '0;
        spur      = 1'b0;
        reset     = 1'b1;
        sb.delete();
        @(negedge clk);
        #1;
        reset = 1'b0;
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_exp_in_valid", 64'(exp_in_valid), 64'd0);
        chk("rst_exp_a", 64'(exp_a), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_c", 64'(resp_c), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        req_valid = '1;
        req_a     = vec(0);
        #1;
        chk("drain_ready", 64'(req_ready), 64'd0);
        for (int i = 1; i <= L; i++) step('1, vec(i), '0, "drain_ready");
        step('1, vec(99), 4'b0001, "first_grant");
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
            req_valid = '0;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
        #2;
    endtask

    initial begin
        logic [N*32-1:0] a;

        // reset, drain window, then fair rotation with everyone valid
        do_reset();
        for (int j = 1; j < 16; j++)
            step('1, vec(j + 10), 4'(1) << (j % 4), "rr_grant");
        step('0, vec(0), '0, "idle_ready");
        wait_drain();
        chk("rr_err", 64'(err), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        // single request from requester 2
        a = vec(40);
        a[64 +: 32] = 32'h3C00;
        step(4'b0100, a, 4'b0100, "single_grant");
        step('0, vec(0), '0, "single_idle");
        chk("single_exp_in_valid", 64'(exp_in_valid), 64'd1);
        chk("single_exp_a", 64'(exp_a), 64'h3C00);
        chk("single_busy", 64'(busy), 64'd1);
        for (int k = 2; k <= 11; k++) begin
            step('0, vec(0), '0, "single_idle");
            if (k == 2) begin
                chk("exp_in_valid_pulse", 64'(exp_in_valid), 64'd0);
                chk("exp_a_hold", 64'(exp_a), 64'h3C00);
            end
            chk("single_busy", 64'(busy), (k <= 10) ? 64'd1 : 64'd0);
        end
        chk("resp_c_hold", 64'(resp_c), 64'h4000);

        // requester 1 streams 20 operands back-to-back
        for (int j = 0; j < 20; j++) begin
            step(4'b0010, vec(100 + j), 4'b0010, "stream_grant");
            chk("stream_occupancy", 64'(dut.count_q > (L + 1)), 64'd0);
        end
        step('0, vec(0), '0, "idle_ready");
        wait_drain();
        chk("stream_err", 64'(err), 64'd0);

        // spurious strobe with an empty FIFO
        @(negedge clk);
        #1;
        chk("spur_err_before", 64'(err), 64'd0);
        spur = 1'b1;
        @(negedge clk);
        #1;
        spur = 1'b0;
        chk("spur_err_set", 64'(err), 64'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("spur_err_sticky", 64'(err), 64'd1);

        // reset with five operations in flight
        for (int j = 0; j < 5; j++)
            step(4'b1000, vec(200 + j), 4'b1000, "flight_grant");
        do_reset();
        chk("flight_err", 64'(err), 64'd0);
        step('0, vec(0), '0, "idle_ready");
        wait_drain();
        chk("final_err", 64'(err), 64'd0);
        chk("final_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
